vecmac_dot_ctrl: RTL and testbench

Job sequencer that drives the 4-lane int8 dot-product MAC (mul4x8x8_wallace) and consumes its results. It accepts a length command and a stream of packed 32-bit operand word pairs. It issues one word pair per beat to the MAC's `in_valid/in_a/in_b` port and counts the returning `out_valid/out_sum` beats, accumulating them into a wide sum. It emits one result per job with a valid/ready handshake, and sits between the operand buffer and the result writeback path.

---
 rtl/vecmac_dot_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_vecmac_dot_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vecmac_dot_ctrl.sv
// Job sequencer for the 4-lane int8 dot-product MAC: issues operand word pairs,
// counts returning partial sums and emits one accumulated result per job.
module vecmac_dot_ctrl #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
  output logic             mac_in_valid,
  output logic [31:0]      mac_in_a,
  output logic [31:0]      mac_in_b,
  input  logic             mac_out_valid,
  input  logic [17:0]      mac_out_sum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             err_spurious
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] issued_q, issued_d;
  logic [LEN_W-1:0] returned_q, returned_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             op_ready_q, op_ready_d;
  logic             mac_in_valid_q, mac_in_valid_d;
  logic [31:0]      mac_in_a_q, mac_in_a_d;
  logic [31:0]      mac_in_b_q, mac_in_b_d;
  logic             res_valid_q, res_valid_d;
  logic [ACC_W-1:0] res_data_q, res_data_d;
  logic             err_q, err_d;

  logic             cmd_hs_s;
  logic             op_hs_s;
  logic             res_hs_s;

  assign cmd_hs_s = cmd_valid & cmd_ready_q;
  assign op_hs_s  = op_valid & op_ready_q;
  assign res_hs_s = res_valid_q & res_ready;

  // Next-state, counters, accumulator and registered-output decode
  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    issued_d       = issued_q;
    returned_d     = returned_q;
    acc_d          = acc_q;
    mac_in_valid_d = 1'b0;
    mac_in_a_d     = mac_in_a_q;
    mac_in_b_d     = mac_in_b_q;
    err_d          = err_q;
    res_data_d     = res_data_q;

    // Returns are counted before the FSM so DRAIN can exit on the final beat.
    if (mac_out_valid) begin
      if ((state_q == ST_ISSUE) || (state_q == ST_DRAIN)) begin
        acc_d      = acc_q + {{(ACC_W-18){1'b0}}, mac_out_sum};
        returned_d = returned_q + LEN_ONE;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      acc_d      = acc_q;
      returned_d = returned_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_hs_s) begin
          len_d      = cmd_len;
          acc_d      = ACC_ZERO;
          issued_d   = LEN_ZERO;
          returned_d = LEN_ZERO;
          if (cmd_len == LEN_ZERO) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (op_hs_s) begin
          mac_in_valid_d = 1'b1;
          mac_in_a_d     = op_a;
          mac_in_b_d     = op_b;
          issued_d       = issued_q + LEN_ONE;
          if (issued_d == len_q) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (returned_d == len_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (res_hs_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake outputs are registered images of the state being entered.
    cmd_ready_d = (state_d == ST_IDLE);
    op_ready_d  = (state_d == ST_ISSUE);
    res_valid_d = (state_d == ST_DONE);
    if (state_d == ST_DONE) begin
      res_data_d = acc_d;
    end else begin
      res_data_d = res_data_q;
    end
  end

  // State, counter, accumulator and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      len_q          <= LEN_ZERO;
      issued_q       <= LEN_ZERO;
      returned_q     <= LEN_ZERO;
      acc_q          <= ACC_ZERO;
      cmd_ready_q    <= 1'b0;
      op_ready_q     <= 1'b0;
      mac_in_valid_q <= 1'b0;
      mac_in_a_q     <= 32'h0000_0000;
      mac_in_b_q     <= 32'h0000_0000;
      res_valid_q    <= 1'b0;
      res_data_q     <= ACC_ZERO;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      issued_q       <= issued_d;
      returned_q     <= returned_d;
      acc_q          <= acc_d;
      cmd_ready_q    <= cmd_ready_d;
      op_ready_q     <= op_ready_d;
      mac_in_valid_q <= mac_in_valid_d;
      mac_in_a_q     <= mac_in_a_d;
      mac_in_b_q     <= mac_in_b_d;
      res_valid_q    <= res_valid_d;
      res_data_q     <= res_data_d;
      err_q          <= err_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign op_ready     = op_ready_q;
  assign mac_in_valid = mac_in_valid_q;
  assign mac_in_a     = mac_in_a_q;
  assign mac_in_b     = mac_in_b_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_vecmac_dot_ctrl.sv
// Directed bench for vecmac_dot_ctrl with a two-stage behavioural MAC model
// on the issue/return port.
module tb_vecmac_dot_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_len;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mac_in_valid;
  logic [31:0] mac_in_a;
  logic [31:0] mac_in_b;
  logic        mac_out_valid;
  logic [17:0] mac_out_sum;
  logic        res_valid;
  logic        res_ready;
  logic [25:0] res_data;
  logic        err_spurious;

  int n_checks = 0;
  int n_fail   = 0;
  int n_issue  = 0;

  logic        p1_v, p2_v;
  logic [17:0] p1_s, p2_s;
  logic        spur_v;
  logic [17:0] spur_s;

  vecmac_dot_ctrl #(.LEN_W(8), .ACC_W(26)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mac_in_valid(mac_in_valid), .mac_in_a(mac_in_a), .mac_in_b(mac_in_b),
    .mac_out_valid(mac_out_valid), .mac_out_sum(mac_out_sum),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] dot4(input logic [31:0] a, input logic [31:0] b);
    logic [17:0] s;
    s = 18'd0;
    for (int k = 0; k < 4; k++) s = s + 18'(a[8*k +: 8]) * 18'(b[8*k +: 8]);
    return s;
  endfunction

  // Behavioural MAC: two-cycle latency, shares rst_n, plus an injectable stray beat.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_v <= 1'b0; p2_v <= 1'b0; p1_s <= 18'd0; p2_s <= 18'd0;
    end else begin
      p1_v <= mac_in_valid; p1_s <= dot4(mac_in_a, mac_in_b);
      p2_v <= p1_v;         p2_s <= p1_s;
    end
  end
  assign mac_out_valid = p2_v | spur_v;
  assign mac_out_sum   = spur_v ? spur_s : p2_s;

  always @(negedge clk) if (mac_in_valid) n_issue++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] len);
    int guard = 0;
    while (!cmd_ready && guard < 300) begin tick(); guard++; end
    if (!cmd_ready) check_eq("cmd_ready_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b1; cmd_len = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_op(input logic [31:0] a, input logic [31:0] b, input int gap,
                         output int stalls);
    int guard = 0;
    stalls = 0;
    op_valid = 1'b0;
    repeat (gap) tick();
    while (!op_ready && guard < 300) begin tick(); guard++; stalls++; end
    if (!op_ready) check_eq("op_ready_timeout", 32'd0, 32'd1);
    op_valid = 1'b1; op_a = a; op_b = b;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic get_res(input string tag, input logic [31:0] exp, input int hold);
    int guard = 0;
    while (!res_valid && guard < 300) begin tick(); guard++; end
    check_eq({tag, "_valid"}, 32'(res_valid), 32'd1);
    check_eq({tag, "_data"}, 32'(res_data), exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      check_eq({tag, "_hold_valid"}, 32'(res_valid), 32'd1);
      check_eq({tag, "_hold_data"}, 32'(res_data), exp);
      check_eq({tag, "_hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_eq({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
    check_eq({tag, "_cmd_ready_back"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    check_eq({tag, "_op_ready"}, 32'(op_ready), 32'd0);
    check_eq({tag, "_mac_in_valid"}, 32'(mac_in_valid), 32'd0);
    check_eq({tag, "_mac_in_a"}, mac_in_a, 32'd0);
    check_eq({tag, "_mac_in_b"}, mac_in_b, 32'd0);
    check_eq({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check_eq({tag, "_res_data"}, 32'(res_data), 32'd0);
    check_eq({tag, "_err"}, 32'(err_spurious), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int stalls;
    int base;
    logic [31:0] gold;
    logic [31:0] va, vb;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = 8'd0; op_valid = 1'b0;
    op_a = 32'd0; op_b = 32'd0; res_ready = 1'b0; spur_v = 1'b0; spur_s = 18'd0;

    repeat (3) tick();
    check_reset_outputs("rst");
    @(negedge clk) rst_n = 1'b1;
    tick();
    check_eq("rst_cmd_ready_after", 32'(cmd_ready), 32'd1);

    // Single word: 4*1 + 3*1 + 2*1 + 1*1 = 10
    base = n_issue;
    send_cmd(8'd1);
    check_eq("single_op_ready", 32'(op_ready), 32'd1);
    send_op(32'h0102_0304, 32'h0101_0101, 0, st);
    check_eq("single_op_ready_drop", 32'(op_ready), 32'd0);
    check_eq("single_mac_in_valid", 32'(mac_in_valid), 32'd1);
    check_eq("single_mac_in_a", mac_in_a, 32'h0102_0304);
    check_eq("single_mac_in_b", mac_in_b, 32'h0101_0101);
    tick();
    check_eq("single_mac_in_valid_pulse", 32'(mac_in_valid), 32'd0);
    check_eq("single_mac_in_a_hold", mac_in_a, 32'h0102_0304);
    get_res("single", 32'd10, 0);
    check_eq("single_issue_count", 32'(n_issue - base), 32'd1);
    check_eq("single_err", 32'(err_spurious), 32'd0);

    // Max job: 255 * 4 * 255 * 255 = 66,325,500
    base = n_issue; stalls = 0;
    send_cmd(8'd255);
    for (int i = 0; i < 255; i++) begin
      send_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, st);
      stalls = stalls + st;
    end
    check_eq("max_stalls", 32'(stalls), 32'd0);
    get_res("max", 32'h03F4_0BFC, 0);
    check_eq("max_issue_count", 32'(n_issue - base), 32'd255);

    // Zero length: result in the cycle right after the command handshake
    base = n_issue;
    send_cmd(8'd0);
    check_eq("zero_res_valid_next", 32'(res_valid), 32'd1);
    check_eq("zero_res_data", 32'(res_data), 32'd0);
    check_eq("zero_op_ready", 32'(op_ready), 32'd0);
    get_res("zero", 32'd0, 0);
    check_eq("zero_issue_count", 32'(n_issue - base), 32'd0);
    check_eq("zero_op_ready_after", 32'(op_ready), 32'd0);

    // Backpressure: operand gaps and res_ready held low for 5 cycles
    base = n_issue; gold = 32'd0;
    send_cmd(8'd8);
    for (int i = 0; i < 8; i++) begin
      va = 32'h0102_0304 + 32'(i) * 32'h0101_0101;
      vb = 32'h1020_3040 ^ 32'(i * 3);
      gold = gold + 32'(dot4(va, vb));
      send_op(va, vb, i % 3, st);
      check_eq("bp_cmd_ready_busy", 32'(cmd_ready), 32'd0);
    end
    get_res("bp", gold, 5);
    check_eq("bp_issue_count", 32'(n_issue - base), 32'd8);

    // Spurious return while idle sets a sticky flag without touching the next job
    spur_v = 1'b1; spur_s = 18'h00100;
    tick();
    spur_v = 1'b0;
    check_eq("spur_err_set", 32'(err_spurious), 32'd1);
    repeat (3) tick();
    check_eq("spur_err_sticky", 32'(err_spurious), 32'd1);
    send_cmd(8'd1);
    send_op(32'h0102_0304, 32'h0101_0101, 0, st);
    get_res("spur_next", 32'd10, 0);
    check_eq("spur_err_still", 32'(err_spurious), 32'd1);

    // Reset in the middle of a 10-pair job, then a clean len=2 job
    send_cmd(8'd10);
    for (int i = 0; i < 3; i++) send_op(32'h0505_0505, 32'h0303_0303, 0, st);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("midrst");
    repeat (2) tick();
    check_reset_outputs("midrst_held");
    @(negedge clk) rst_n = 1'b1;
    tick();
    check_eq("midrst_cmd_ready_after", 32'(cmd_ready), 32'd1);
    check_eq("midrst_res_valid_after", 32'(res_valid), 32'd0);
    // 13*4 + 12*3 + 11*2 + 10*1 = 120, plus 255*1 = 375
    send_cmd(8'd2);
    send_op(32'h0A0B_0C0D, 32'h0102_0304, 0, st);
    send_op(32'hFFFF_FFFF, 32'h0000_0001, 0, st);
    get_res("post_rst", 32'd375, 0);
    check_eq("post_rst_err", 32'(err_spurious), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
